mem_arb_ctrl: RTL and testbench
===============================

MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: request address width.
REQ-002 SHALL have parameter BLK_W, default 128: memory block/data width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255: maximum busy cycles before abort; 0 disables the timeout.
REQ-004 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have ports i_req_valid_i (input, 1) and i_req_addr_i (input, ADDR_W): instruction read request.
REQ-007 SHALL have port i_req_ready_o, output, 1: instruction request accepted this cycle when high with valid.
REQ-008 SHALL have ports i_res_valid_o (output, 1) and i_res_data_o (output, BLK_W): instruction response.
REQ-009 SHALL have ports d_req_valid_i (input, 1), d_req_addr_i (input, ADDR_W), d_req_wmask_i (input, BLK_W/8) and d_req_wdata_i (input, BLK_W): data request; a zero mask means a read.
REQ-010 SHALL have ports d_req_ready_o (output, 1), d_res_valid_o (output, 1) and d_res_data_o (output, BLK_W): data handshake and response.
REQ-011 SHALL have ports mem_req_valid_o (output, 1), mem_req_addr_o (output, ADDR_W), mem_req_wmask_o (output, BLK_W/8) and mem_req_wdata_o (output, BLK_W): memory request.
REQ-012 SHALL have ports mem_ready_i (input, 1) and mem_rdata_i (input, BLK_W): memory completion and read data.
REQ-013 SHALL have port timeout_o, output, 1: one-cycle abort pulse.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, with at most one outstanding memory transaction.
REQ-015 SHALL, in IDLE, drive a ready to exactly one requesting side per cycle; both readies SHALL be low outside IDLE.
REQ-016 SHALL grant a side that requests alone in IDLE.
REQ-017 SHALL grant the side not served last when both sides request; after reset, D SHALL win the first tie.
REQ-018 SHALL, on acceptance (valid && ready in cycle N), latch addr/wmask/wdata (I side: wmask forced 0, wdata 0) and enter BUSY_I or BUSY_D at N+1.
REQ-019 SHALL hold mem_req_valid_o high and the mem_req_* fields stable from N+1 until completion; in IDLE it SHALL drive all mem_req_* outputs to 0.
REQ-020 SHALL complete when mem_ready_i is high in a BUSY state (cycle M >= N+1), then return to IDLE at M+1.
REQ-021 SHALL pulse the owner's res_valid_o for exactly cycle M+1, with res_data_o = mem_rdata_i registered at M; the non-owner's res_valid_o SHALL stay low.
REQ-022 SHALL hold res_data_o at its last value when res_valid_o is low.
REQ-023 SHALL allow a new acceptance in cycle M+1, giving back-to-back throughput of one transaction per two cycles when memory responds in 1 cycle.
REQ-024 SHALL ignore mem_ready_i while in IDLE.
REQ-025 SHALL count busy cycles with a counter cleared on acceptance, where the counter width is clog2(TIMEOUT_CYC+1).
REQ-026 SHALL, when TIMEOUT_CYC != 0, the count reaches TIMEOUT_CYC and mem_ready_i is still low, return to IDLE next cycle and pulse timeout_o there; in that same cycle it SHALL pulse the owner's res_valid_o with res_data_o = 0.
REQ-027 SHALL give mem_ready_i priority over timeout when both occur in the same cycle (normal completion, no timeout_o).
REQ-028 SHALL update the last-served flag on every acceptance; timed-out transactions SHALL count as served.
REQ-029 SHALL let requesters drop valid at any time before acceptance without side effects.

Reset
REQ-030 SHALL, while rst_ni is low, asynchronously force state IDLE, last-served flag I (so that D wins the first tie), and busy counter 0.
REQ-031 SHALL, during reset, drive all outputs to 0 except readies, which follow IDLE rules once rst_ni deasserts; an in-flight transaction SHALL be abandoned with no response.

Verification
REQ-032 SHALL verify single I read at 0x0000_1000 with memory latency 3: ready at N; mem_req_valid_o high N+1..N+3; i_res_valid_o at N+4 with data 0xA5..A5.
REQ-033 SHALL verify both sides requesting continuously after reset: grants alternate D, I, D, I; each response goes only to its owner.
REQ-034 SHALL verify a D write with addr 0x40 and wmask 0x000F: mem_req_wmask_o = 0x000F and wdata stable until mem_ready_i, then d_res_valid_o is pulsed.
REQ-035 SHALL verify that with TIMEOUT_CYC=4 and mem_ready_i never asserted, timeout_o and d_res_valid_o pulse with data 0 and the FSM returns to IDLE; a following I request is granted.
REQ-036 SHALL verify that asserting rst_ni low mid-BUSY_D immediately drops mem_req_valid_o and produces no response; after release the first tie is granted to D.
REQ-037 SHALL verify that mem_ready_i coincident with the timeout threshold yields a normal response and no timeout_o.

Source files
------------

// File: rtl/mem_arb_ctrl_if.sv
// Bus bundle between the instruction/data requesters, the memory port and mem_arb_ctrl.
// slave is the arbiter's view; master is the view of the requesters and the memory.
interface mem_arb_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int BLK_W  = 128
);
  logic                 i_req_valid_i;
  logic [ADDR_W-1:0]    i_req_addr_i;
  logic                 i_req_ready_o;
  logic                 i_res_valid_o;
  logic [BLK_W-1:0]     i_res_data_o;

  logic                 d_req_valid_i;
  logic [ADDR_W-1:0]    d_req_addr_i;
  logic [BLK_W/8-1:0]   d_req_wmask_i;
  logic [BLK_W-1:0]     d_req_wdata_i;
  logic                 d_req_ready_o;
  logic                 d_res_valid_o;
  logic [BLK_W-1:0]     d_res_data_o;

  logic                 mem_req_valid_o;
  logic [ADDR_W-1:0]    mem_req_addr_o;
  logic [BLK_W/8-1:0]   mem_req_wmask_o;
  logic [BLK_W-1:0]     mem_req_wdata_o;
  logic                 mem_ready_i;
  logic [BLK_W-1:0]     mem_rdata_i;

  logic                 timeout_o;

  modport slave (
    input  i_req_valid_i, i_req_addr_i,
    input  d_req_valid_i, d_req_addr_i, d_req_wmask_i, d_req_wdata_i,
    input  mem_ready_i, mem_rdata_i,
    output i_req_ready_o, i_res_valid_o, i_res_data_o,
    output d_req_ready_o, d_res_valid_o, d_res_data_o,
    output mem_req_valid_o, mem_req_addr_o, mem_req_wmask_o, mem_req_wdata_o,
    output timeout_o
  );

  modport master (
    output i_req_valid_i, i_req_addr_i,
    output d_req_valid_i, d_req_addr_i, d_req_wmask_i, d_req_wdata_i,
    output mem_ready_i, mem_rdata_i,
    input  i_req_ready_o, i_res_valid_o, i_res_data_o,
    input  d_req_ready_o, d_res_valid_o, d_res_data_o,
    input  mem_req_valid_o, mem_req_addr_o, mem_req_wmask_o, mem_req_wdata_o,
    input  timeout_o
  );
endinterface

// File: rtl/mem_arb_ctrl.sv
// Arbitrates instruction and data requests onto a single-outstanding memory port,
// alternating on ties and aborting a transaction that stays busy too long.
module mem_arb_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int BLK_W       = 128,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  mem_arb_ctrl_if.slave bus
);
  localparam int MASK_W = BLK_W / 8;
  localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
  localparam bit TO_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                last_d_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                grant_i_s;
  logic                grant_d_s;
  logic                done_s;
  logic                abort_s;

  logic                mem_valid_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [MASK_W-1:0]   mem_wmask_r;
  logic [BLK_W-1:0]    mem_wdata_r;
  logic                i_res_valid_r;
  logic [BLK_W-1:0]    i_res_data_r;
  logic                d_res_valid_r;
  logic [BLK_W-1:0]    d_res_data_r;
  logic                timeout_r;

  // Next-state, grant and completion/abort decode.
  always_comb begin
    state_nxt_s = state_r;
    grant_i_s   = 1'b0;
    grant_d_s   = 1'b0;
    done_s      = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      IDLE: begin
        // D wins when alone, or on a tie when I was served last.
        if (bus.d_req_valid_i && (!bus.i_req_valid_i || !last_d_r)) begin
          grant_d_s   = 1'b1;
          state_nxt_s = BUSY_D;
        end else if (bus.i_req_valid_i) begin
          grant_i_s   = 1'b1;
          state_nxt_s = BUSY_I;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ready_i) begin
          done_s      = 1'b1;
          state_nxt_s = IDLE;
        end else if (TO_EN && (cnt_r == CNT_MAX)) begin
          abort_s     = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, request latch, busy counter and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r       <= IDLE;
      last_d_r      <= 1'b0;
      cnt_r         <= '0;
      mem_valid_r   <= 1'b0;
      mem_addr_r    <= '0;
      mem_wmask_r   <= '0;
      mem_wdata_r   <= '0;
      i_res_valid_r <= 1'b0;
      i_res_data_r  <= '0;
      d_res_valid_r <= 1'b0;
      d_res_data_r  <= '0;
      timeout_r     <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      i_res_valid_r <= 1'b0;
      d_res_valid_r <= 1'b0;
      timeout_r     <= 1'b0;
      if (grant_d_s || grant_i_s) begin
        mem_valid_r <= 1'b1;
        mem_addr_r  <= grant_d_s ? bus.d_req_addr_i : bus.i_req_addr_i;
        mem_wmask_r <= grant_d_s ? bus.d_req_wmask_i : '0;
        mem_wdata_r <= grant_d_s ? bus.d_req_wdata_i : '0;
        cnt_r       <= '0;
        last_d_r    <= grant_d_s;
      end else if (done_s || abort_s) begin
        mem_valid_r <= 1'b0;
        mem_addr_r  <= '0;
        mem_wmask_r <= '0;
        mem_wdata_r <= '0;
        timeout_r   <= abort_s;
        if (state_r == BUSY_D) begin
          d_res_valid_r <= 1'b1;
          d_res_data_r  <= done_s ? bus.mem_rdata_i : '0;
        end else begin
          i_res_valid_r <= 1'b1;
          i_res_data_r  <= done_s ? bus.mem_rdata_i : '0;
        end
      end else if (state_r != IDLE) begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end
    end
  end

  assign bus.i_req_ready_o   = grant_i_s;
  assign bus.d_req_ready_o   = grant_d_s;
  assign bus.mem_req_valid_o = mem_valid_r;
  assign bus.mem_req_addr_o  = mem_addr_r;
  assign bus.mem_req_wmask_o = mem_wmask_r;
  assign bus.mem_req_wdata_o = mem_wdata_r;
  assign bus.i_res_valid_o   = i_res_valid_r;
  assign bus.i_res_data_o    = i_res_data_r;
  assign bus.d_res_valid_o   = d_res_valid_r;
  assign bus.d_res_data_o    = d_res_data_r;
  assign bus.timeout_o       = timeout_r;
endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench for mem_arb_ctrl: latency, alternation, writes, timeout, reset abandonment.
module tb_mem_arb_ctrl;
  logic clk_i;
  logic rst_ni;
  int   checks;
  int   errors;

  mem_arb_ctrl_if #(.ADDR_W(32), .BLK_W(128)) bus ();

  mem_arb_ctrl #(.ADDR_W(32), .BLK_W(128), .TIMEOUT_CYC(4)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [127:0] w3;
  logic [127:0] exp_data;

  initial begin
    checks = 0;
    errors = 0;
    rst_ni = 1'b0;
    bus.i_req_valid_i = 1'b0;
    bus.i_req_addr_i  = 32'h0;
    bus.d_req_valid_i = 1'b0;
    bus.d_req_addr_i  = 32'h0;
    bus.d_req_wmask_i = 16'h0;
    bus.d_req_wdata_i = 128'h0;
    bus.mem_ready_i   = 1'b0;
    bus.mem_rdata_i   = 128'h0;
    w3 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    // Reset state
    tick(); tick();
    mid();
    chk("rst_mem_valid", bus.mem_req_valid_o, 128'h0);
    chk("rst_mem_addr", bus.mem_req_addr_o, 128'h0);
    chk("rst_res_valid", {bus.i_res_valid_o, bus.d_res_valid_o}, 128'h0);
    chk("rst_timeout", bus.timeout_o, 128'h0);
    tick();
    rst_ni = 1'b1;
    mid();
    chk("idle_readies", {bus.i_req_ready_o, bus.d_req_ready_o}, 128'h0);
    tick();

    // Single I read, memory latency 3
    bus.i_req_valid_i = 1'b1;
    bus.i_req_addr_i  = 32'h0000_1000;
    mid();
    chk("t1_i_ready", bus.i_req_ready_o, 128'h1);
    chk("t1_d_ready", bus.d_req_ready_o, 128'h0);
    tick();
    bus.i_req_valid_i = 1'b0;
    mid();
    chk("t1_mem_valid_n1", bus.mem_req_valid_o, 128'h1);
    chk("t1_mem_addr", bus.mem_req_addr_o, 128'h1000);
    chk("t1_mem_wmask", bus.mem_req_wmask_o, 128'h0);
    chk("t1_ready_busy", bus.i_req_ready_o, 128'h0);
    tick();
    mid();
    chk("t1_mem_valid_n2", bus.mem_req_valid_o, 128'h1);
    tick();
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = {16{8'hA5}};
    mid();
    chk("t1_mem_valid_n3", bus.mem_req_valid_o, 128'h1);
    tick();
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = 128'h0;
    mid();
    chk("t1_i_res_valid", bus.i_res_valid_o, 128'h1);
    chk("t1_i_res_data", bus.i_res_data_o, {16{8'hA5}});
    chk("t1_d_res_valid", bus.d_res_valid_o, 128'h0);
    chk("t1_mem_idle", bus.mem_req_valid_o, 128'h0);
    chk("t1_timeout", bus.timeout_o, 128'h0);
    tick();
    mid();
    chk("t1_i_res_drop", bus.i_res_valid_o, 128'h0);
    chk("t1_i_res_hold", bus.i_res_data_o, {16{8'hA5}});
    tick();

    // Both sides requesting continuously after reset: D, I, D, I
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    bus.i_req_valid_i = 1'b1;
    bus.i_req_addr_i  = 32'h0000_0100;
    bus.d_req_valid_i = 1'b1;
    bus.d_req_addr_i  = 32'h0000_0200;
    bus.d_req_wmask_i = 16'h0;
    bus.mem_ready_i   = 1'b1;
    for (int g = 0; g < 5; g++) begin
      if (g == 4) begin
        bus.i_req_valid_i = 1'b0;
        bus.d_req_valid_i = 1'b0;
      end
      bus.mem_rdata_i = {96'h0, 32'hC0DE_0000 | 32'(g)};
      mid();
      if (g > 0) begin
        exp_data = {96'h0, 32'hC0DE_0000 | 32'(g - 1)};
        chk("t2_d_res_valid", bus.d_res_valid_o, 128'((g - 1) % 2 == 0));
        chk("t2_i_res_valid", bus.i_res_valid_o, 128'((g - 1) % 2 == 1));
        chk("t2_res_data", ((g - 1) % 2 == 0) ? bus.d_res_data_o : bus.i_res_data_o, exp_data);
      end
      if (g < 4) begin
        chk("t2_d_ready", bus.d_req_ready_o, 128'(g % 2 == 0));
        chk("t2_i_ready", bus.i_req_ready_o, 128'(g % 2 == 1));
        tick();
        mid();
        chk("t2_busy_readies", {bus.i_req_ready_o, bus.d_req_ready_o}, 128'h0);
        chk("t2_mem_addr", bus.mem_req_addr_o, (g % 2 == 0) ? 128'h200 : 128'h100);
      end
      tick();
    end
    bus.mem_ready_i = 1'b0;

    // D write with mask 0x000F; fields must stay stable while memory stalls
    bus.d_req_valid_i = 1'b1;
    bus.d_req_addr_i  = 32'h0000_0040;
    bus.d_req_wmask_i = 16'h000F;
    bus.d_req_wdata_i = w3;
    mid();
    chk("t3_d_ready", bus.d_req_ready_o, 128'h1);
    tick();
    bus.d_req_valid_i = 1'b0;
    bus.d_req_wmask_i = 16'hFFFF;
    bus.d_req_wdata_i = {128{1'b1}};
    mid();
    chk("t3_mem_addr", bus.mem_req_addr_o, 128'h40);
    chk("t3_mem_wmask", bus.mem_req_wmask_o, 128'h000F);
    chk("t3_mem_wdata_n1", bus.mem_req_wdata_o, w3);
    tick();
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 128'hFEED;
    mid();
    chk("t3_mem_wdata_n2", bus.mem_req_wdata_o, w3);
    chk("t3_mem_valid_n2", bus.mem_req_valid_o, 128'h1);
    tick();
    bus.mem_ready_i = 1'b0;
    mid();
    chk("t3_d_res_valid", bus.d_res_valid_o, 128'h1);
    chk("t3_i_res_valid", bus.i_res_valid_o, 128'h0);
    chk("t3_d_res_data", bus.d_res_data_o, 128'hFEED);
    chk("t3_mem_idle", bus.mem_req_valid_o, 128'h0);
    tick();

    // Timeout with TIMEOUT_CYC=4, then an I request is granted
    bus.d_req_valid_i = 1'b1;
    bus.d_req_addr_i  = 32'h0000_0080;
    bus.d_req_wmask_i = 16'h0;
    bus.mem_rdata_i   = 128'hBAD;
    mid();
    chk("t4_d_ready", bus.d_req_ready_o, 128'h1);
    tick();
    bus.d_req_valid_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      mid();
      chk("t4_mem_valid_busy", bus.mem_req_valid_o, 128'h1);
      chk("t4_no_early_timeout", bus.timeout_o, 128'h0);
      tick();
    end
    bus.i_req_valid_i = 1'b1;
    bus.i_req_addr_i  = 32'h0000_0300;
    mid();
    chk("t4_timeout", bus.timeout_o, 128'h1);
    chk("t4_d_res_valid", bus.d_res_valid_o, 128'h1);
    chk("t4_d_res_data", bus.d_res_data_o, 128'h0);
    chk("t4_mem_idle", bus.mem_req_valid_o, 128'h0);
    chk("t4_i_ready", bus.i_req_ready_o, 128'h1);
    tick();
    bus.i_req_valid_i = 1'b0;
    bus.mem_ready_i   = 1'b1;
    bus.mem_rdata_i   = 128'h5A;
    mid();
    chk("t4_timeout_drop", bus.timeout_o, 128'h0);
    chk("t4_i_mem_addr", bus.mem_req_addr_o, 128'h300);
    tick();
    bus.mem_ready_i = 1'b0;
    mid();
    chk("t4_i_res_valid", bus.i_res_valid_o, 128'h1);
    chk("t4_i_res_data", bus.i_res_data_o, 128'h5A);
    tick();

    // mem_ready exactly at the timeout threshold: normal completion
    bus.d_req_valid_i = 1'b1;
    bus.d_req_addr_i  = 32'h0000_00C0;
    mid();
    chk("t5_d_ready", bus.d_req_ready_o, 128'h1);
    tick();
    bus.d_req_valid_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      mid();
      chk("t5_mem_valid_busy", bus.mem_req_valid_o, 128'h1);
      tick();
    end
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 128'hC0FFEE;
    mid();
    tick();
    bus.mem_ready_i = 1'b0;
    mid();
    chk("t5_d_res_valid", bus.d_res_valid_o, 128'h1);
    chk("t5_d_res_data", bus.d_res_data_o, 128'hC0FFEE);
    chk("t5_no_timeout", bus.timeout_o, 128'h0);
    tick();

    // Reset mid-BUSY_D: no response, then D wins the first tie
    bus.d_req_valid_i = 1'b1;
    bus.d_req_addr_i  = 32'h0000_0400;
    mid();
    chk("t6_d_ready", bus.d_req_ready_o, 128'h1);
    tick();
    bus.d_req_valid_i = 1'b0;
    mid();
    chk("t6_mem_valid", bus.mem_req_valid_o, 128'h1);
    tick();
    rst_ni = 1'b0;
    bus.mem_ready_i = 1'b1;
    #1;
    chk("t6_rst_mem_valid", bus.mem_req_valid_o, 128'h0);
    chk("t6_rst_mem_addr", bus.mem_req_addr_o, 128'h0);
    mid();
    chk("t6_rst_no_res", {bus.i_res_valid_o, bus.d_res_valid_o}, 128'h0);
    tick();
    rst_ni = 1'b1;
    mid();
    chk("t6_post_no_res", {bus.i_res_valid_o, bus.d_res_valid_o}, 128'h0);
    chk("t6_idle_ignore_ready", bus.mem_req_valid_o, 128'h0);
    tick();
    bus.i_req_valid_i = 1'b1;
    bus.i_req_addr_i  = 32'h0000_0500;
    bus.d_req_valid_i = 1'b1;
    bus.d_req_addr_i  = 32'h0000_0600;
    mid();
    chk("t6_tie_d_ready", bus.d_req_ready_o, 128'h1);
    chk("t6_tie_i_ready", bus.i_req_ready_o, 128'h0);
    tick();
    bus.i_req_valid_i = 1'b0;
    bus.d_req_valid_i = 1'b0;
    mid();
    chk("t6_tie_mem_addr", bus.mem_req_addr_o, 128'h600);
    tick();
    bus.mem_ready_i = 1'b0;
    mid();
    chk("t6_tie_d_res", bus.d_res_valid_o, 128'h1);
    chk("t6_tie_i_res", bus.i_res_valid_o, 128'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
